// File: rtl/i2c_master_if.sv
// Command/data handshake between the system side and the i2c_master controller.
interface i2c_master_if;
  logic       START;
  logic [6:0] ADDR;
  logic       RW;
  logic [3:0] NBYTES;
  logic [7:0] IDATA;
  logic       DREQ;
  logic [7:0] ODATA;
  logic       DRDY;
  logic       NACK;
  logic       BUSY;
  logic       DONE;

  modport master (input  START, ADDR, RW, NBYTES, IDATA,
                  output DREQ, ODATA, DRDY, NACK, BUSY, DONE);
  modport slave  (output START, ADDR, RW, NBYTES, IDATA,
                  input  DREQ, ODATA, DRDY, NACK, BUSY, DONE);
endinterface

// File: rtl/i2c_master.sv
// Single-master I2C controller: START, {ADDR,RW}, 1..15 data bytes, STOP.
// Open-drain SCL/SDA, four quarters of CLK_DIV cycles per bit, slave clock stretching honoured.
module i2c_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic         CLK,
  input  logic         NRST,
  inout  wire          SCL,
  inout  wire          SDA,
  i2c_master_if.master bus
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ACKA, ST_DATA, ST_ACKD, ST_STOP
  } state_e;

  localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  bytecnt_q, bytecnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [7:0]  odata_q, odata_d;
  logic        drdy_q, drdy_d;
  logic        nack_q, nack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  scl_sync_q, scl_sync_d;
  logic [1:0]  sda_sync_q, sda_sync_d;
  logic        scl_s, sda_s, bit_state, stall, qend, dreq, scl_oe, sda_oe;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign bit_state = state_q inside {ST_ADDR, ST_ACKA, ST_DATA, ST_ACKD};
  // The released-SCL quarter waits at count 0 until the synchronized line is seen high.
  assign stall = !scl_s && ((bit_state && quarter_q == 2'd2) ||
                            (state_q == ST_STOP && quarter_q == 2'd1));
  assign qend  = (state_q != ST_IDLE) && !stall && (qcnt_q == QMAX);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= ST_IDLE;
      qcnt_q     <= '0;
      quarter_q  <= '0;
      bitcnt_q   <= '0;
      bytecnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      odata_q    <= '0;
      drdy_q     <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      quarter_q  <= quarter_d;
      bitcnt_q   <= bitcnt_d;
      bytecnt_q  <= bytecnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      odata_q    <= odata_d;
      drdy_q     <= drdy_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    quarter_d  = quarter_q;
    bitcnt_d   = bitcnt_q;
    bytecnt_d  = bytecnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    odata_d    = odata_q;
    drdy_d     = 1'b0;
    nack_d     = nack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dreq       = 1'b0;
    scl_sync_d = {scl_sync_q[0], SCL};
    sda_sync_d = {sda_sync_q[0], SDA};

    if (state_q != ST_IDLE) begin
      if (stall) begin
        qcnt_d = '0;
      end else if (qend) begin
        qcnt_d    = '0;
        quarter_d = quarter_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 16'd1;
      end
    end

    if (qend && bit_state && quarter_q == 2'd2) begin
      ack_d = sda_s;
      if (state_q == ST_DATA && rw_q) shift_d = {shift_q[6:0], sda_s};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d   = ST_START;
          busy_d    = 1'b1;
          nack_d    = 1'b0;
          addr_d    = bus.ADDR;
          rw_d      = bus.RW;
          bytecnt_d = (bus.NBYTES == 4'd0) ? 4'd1 : bus.NBYTES;
          qcnt_d    = '0;
          quarter_d = '0;
        end
      end
      ST_START: begin
        if (qend && quarter_q == 2'd1) begin
          state_d   = ST_ADDR;
          quarter_d = '0;
          bitcnt_d  = '0;
          shift_d   = {addr_q, rw_q};
        end
      end
      ST_ADDR, ST_DATA: begin
        if (qend && quarter_q == 2'd3) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (!(state_q == ST_DATA && rw_q)) shift_d = {shift_q[6:0], 1'b0};
          if (bitcnt_q == 3'd7) begin
            state_d = (state_q == ST_ADDR) ? ST_ACKA : ST_ACKD;
            if (state_q == ST_DATA && rw_q) begin
              odata_d = shift_q;
              drdy_d  = 1'b1;
            end
          end
        end
      end
      ST_ACKA: begin
        if (qend && quarter_q == 2'd3) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
            if (!rw_q) begin
              dreq    = 1'b1;
              shift_d = bus.IDATA;
            end
          end
        end
      end
      ST_ACKD: begin
        if (qend && quarter_q == 2'd3) begin
          bytecnt_d = bytecnt_q - 4'd1;
          if (!rw_q && ack_q) begin
            nack_d  = 1'b1;
            state_d = ST_STOP;
          end else if (bytecnt_q > 4'd1) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
            if (!rw_q) begin
              dreq    = 1'b1;
              shift_d = bus.IDATA;
            end
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (qend && quarter_q == 2'd2) begin
          state_d   = ST_IDLE;
          quarter_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line drives decode straight from registered state so an async reset releases both pins at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      ST_START: sda_oe = 1'b1;
      ST_ADDR: begin
        scl_oe = (quarter_q < 2'd2);
        sda_oe = !shift_q[7];
      end
      ST_DATA: begin
        scl_oe = (quarter_q < 2'd2);
        sda_oe = !rw_q && !shift_q[7];
      end
      ST_ACKA: scl_oe = (quarter_q < 2'd2);
      ST_ACKD: begin
        scl_oe = (quarter_q < 2'd2);
        sda_oe = rw_q && (bytecnt_q > 4'd1);
      end
      ST_STOP: begin
        scl_oe = (quarter_q == 2'd0);
        sda_oe = (quarter_q < 2'd2);
      end
      default: ;
    endcase
  end

  assign SCL       = scl_oe ? 1'b0 : 1'bz;
  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign bus.DREQ  = dreq;
  assign bus.ODATA = odata_q;
  assign bus.DRDY  = drdy_q;
  assign bus.NACK  = nack_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
endmodule
